control_unit: RTL and testbench

- Multi-cycle controller and datapath that drives the 16x4 data memory: fetches 12-bit instructions, holds an 8x4 register file, and executes ALU, immediate, load and store operations.
- Issues the data memory's address, write_data, write_enable and read_enable.
- Consumes the memory's combinational read_data.
- Sits directly upstream of the data memory and downstream of a combinational instruction ROM.

---
 rtl/ctrl_pkg.sv | 45 ++++
 rtl/control_unit_if.sv | 21 ++
 rtl/reg_file_8x4.sv | 38 +++
 rtl/control_unit.sv | 193 +++++++++++++++++++
 tb/tb_control_unit.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle control unit.
package ctrl_pkg;

   localparam int DATA_W  = 4;
   localparam int ADDR_W  = 4;
   localparam int INSTR_W = 12;
   localparam int REG_AW  = 3;

   // Instruction field positions
   localparam int OP_HI  = 11;
   localparam int OP_LO  = 9;
   localparam int RA_HI  = 8;
   localparam int RA_LO  = 6;
   localparam int RB_HI  = 5;
   localparam int RB_LO  = 3;
   localparam int RD_HI  = 2;
   localparam int RD_LO  = 0;
   localparam int FLD_HI = 7;
   localparam int FLD_LO = 4;

   typedef enum logic [2:0] {
      OP_LOAD  = 3'd0,
      OP_STORE = 3'd1,
      OP_ADD   = 3'd2,
      OP_SUB   = 3'd3,
      OP_LDI   = 3'd4,
      OP_JMP   = 3'd5,
      OP_BEQZ  = 3'd6,
      OP_HALT  = 3'd7
   } opcode_e;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      HALT   = 3'd4
   } state_e;

   // Extract the opcode from an instruction word
   function automatic opcode_e get_op(input logic [INSTR_W-1:0] ir);
      return opcode_e'(ir[OP_HI:OP_LO]);
   endfunction

endpackage

// File: rtl/control_unit_if.sv
// Data-memory bus between the control unit (master) and the 16x4 memory (slave).
interface control_unit_if;
   import ctrl_pkg::*;

   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_write_data;
   logic              mem_write_enable;
   logic              mem_read_enable;
   logic [DATA_W-1:0] mem_read_data;

   modport master (
      output mem_address, mem_write_data, mem_write_enable, mem_read_enable,
      input  mem_read_data
   );

   modport slave (
      input  mem_address, mem_write_data, mem_write_enable, mem_read_enable,
      output mem_read_data
   );

endinterface

// File: rtl/reg_file_8x4.sv
// 8x4 register file: two combinational read ports, one synchronous write
// port, a debug read port, synchronous clear on reset.
module reg_file_8x4
   import ctrl_pkg::*;
#(
   parameter int NUM_REGS = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] ra_addr_i,
   input  logic [REG_AW-1:0] rb_addr_i,
   output logic [DATA_W-1:0] ra_data_o,
   output logic [DATA_W-1:0] rb_data_o,
   input  logic              we_i,
   input  logic [REG_AW-1:0] wa_i,
   input  logic [DATA_W-1:0] wd_i,
   input  logic [REG_AW-1:0] dbg_sel_i,
   output logic [DATA_W-1:0] dbg_data_o
);

   logic [DATA_W-1:0] regs_q [NUM_REGS];

   // Register storage: clear on reset, single write per cycle otherwise
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i) begin
         regs_q[wa_i] <= wd_i;
      end
   end

   assign ra_data_o  = regs_q[ra_addr_i];
   assign rb_data_o  = regs_q[rb_addr_i];
   assign dbg_data_o = regs_q[dbg_sel_i];

endmodule

// File: rtl/control_unit.sv
// Multi-cycle controller driving a 16x4 data memory.
// Optional macro CTRL_BRANCH_EN enables JMP/BEQZ; when undefined both
// opcodes execute as NOPs and no branch logic is built.
module control_unit
   import ctrl_pkg::*;
#(
   parameter logic [ADDR_W-1:0] START_PC = 4'd0,
   parameter int                NUM_REGS = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   output logic [ADDR_W-1:0]  instr_addr,
   input  logic [INSTR_W-1:0] instr_data,
   control_unit_if.master     mem,
   output logic               busy,
   output logic               halted,
   input  logic [REG_AW-1:0]  dbg_sel,
   output logic [DATA_W-1:0]  dbg_data
);

   state_e             state_q;
   logic [ADDR_W-1:0]  pc_q;
   logic [INSTR_W-1:0] ir_q;
   logic [DATA_W-1:0]  opa_q;
   logic [DATA_W-1:0]  opb_q;
   logic [ADDR_W-1:0]  mem_addr_q;
   logic [DATA_W-1:0]  mem_wdata_q;
   logic               mem_we_q;
   logic               mem_re_q;
   logic               busy_q;
   logic               halted_q;

   opcode_e            op_s;
   logic [REG_AW-1:0]  ra_s;
   logic [REG_AW-1:0]  rb_s;
   logic [REG_AW-1:0]  rd_s;
   logic [DATA_W-1:0]  field_s;
   logic [REG_AW-1:0]  rb_sel_s;
   logic [DATA_W-1:0]  rf_ra_s;
   logic [DATA_W-1:0]  rf_rb_s;
   logic               rf_we_s;
   logic [DATA_W-1:0]  rf_wd_s;
   logic [ADDR_W-1:0]  pc_d;

   assign op_s    = get_op(ir_q);
   assign ra_s    = ir_q[RA_HI:RA_LO];
   assign rb_s    = ir_q[RB_HI:RB_LO];
   assign rd_s    = ir_q[RD_HI:RD_LO];
   assign field_s = ir_q[FLD_HI:FLD_LO];

   // Second read port sees rb for register-form ops, rd otherwise (STORE data, BEQZ test)
   always_comb begin
      rb_sel_s = rd_s;
      case (op_s)
         OP_ADD, OP_SUB: rb_sel_s = rb_s;
         default:        rb_sel_s = rd_s;
      endcase
   end

   reg_file_8x4 #(.NUM_REGS(NUM_REGS)) u_rf (
      .clk        (clk),
      .reset      (reset),
      .ra_addr_i  (ra_s),
      .rb_addr_i  (rb_sel_s),
      .ra_data_o  (rf_ra_s),
      .rb_data_o  (rf_rb_s),
      .we_i       (rf_we_s),
      .wa_i       (rd_s),
      .wd_i       (rf_wd_s),
      .dbg_sel_i  (dbg_sel),
      .dbg_data_o (dbg_data)
   );

   // EXEC-stage ALU, register write-back and next-PC selection
   always_comb begin
      rf_we_s = 1'b0;
      rf_wd_s = '0;
      pc_d    = pc_q + 4'd1;
      if (state_q == EXEC) begin
         case (op_s)
            OP_LOAD: begin
               rf_we_s = 1'b1;
               rf_wd_s = mem.mem_read_data;
            end
            OP_ADD: begin
               rf_we_s = 1'b1;
               rf_wd_s = opa_q + opb_q;
            end
            OP_SUB: begin
               rf_we_s = 1'b1;
               rf_wd_s = opa_q - opb_q;
            end
            OP_LDI: begin
               rf_we_s = 1'b1;
               rf_wd_s = field_s;
            end
`ifdef CTRL_BRANCH_EN
            OP_JMP: begin
               pc_d = field_s;
            end
            OP_BEQZ: begin
               if (opb_q == 4'd0) begin
                  pc_d = field_s;
               end else begin
                  pc_d = pc_q + 4'd1;
               end
            end
`endif
            default: begin
               rf_we_s = 1'b0;
            end
         endcase
      end else begin
         rf_we_s = 1'b0;
      end
   end

   // Main FSM with registered memory strobes and status outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         pc_q        <= START_PC;
         ir_q        <= '0;
         opa_q       <= '0;
         opb_q       <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_we_q    <= 1'b0;
         mem_re_q    <= 1'b0;
         busy_q      <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         // Memory strobes are single-cycle: cleared unless set below
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_we_q    <= 1'b0;
         mem_re_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= FETCH;
                  busy_q  <= 1'b1;
               end
            end
            FETCH: begin
               ir_q    <= instr_data;
               state_q <= DECODE;
            end
            DECODE: begin
               opa_q <= rf_ra_s;
               opb_q <= rf_rb_s;
               if (op_s == OP_HALT) begin
                  state_q  <= HALT;
                  busy_q   <= 1'b0;
                  halted_q <= 1'b1;
               end else begin
                  state_q <= EXEC;
                  if (op_s == OP_STORE) begin
                     mem_we_q    <= 1'b1;
                     mem_addr_q  <= field_s;
                     mem_wdata_q <= rf_rb_s;
                  end else if (op_s == OP_LOAD) begin
                     mem_re_q   <= 1'b1;
                     mem_addr_q <= field_s;
                  end
               end
            end
            EXEC: begin
               pc_q    <= pc_d;
               state_q <= FETCH;
            end
            HALT: begin
               state_q <= HALT;
            end
            default: begin
               state_q  <= IDLE;
               busy_q   <= 1'b0;
               halted_q <= 1'b0;
            end
         endcase
      end
   end

   assign instr_addr           = pc_q;
   assign mem.mem_address      = mem_addr_q;
   assign mem.mem_write_data   = mem_wdata_q;
   assign mem.mem_write_enable = mem_we_q;
   assign mem.mem_read_enable  = mem_re_q;
   assign busy                 = busy_q;
   assign halted               = halted_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit with a behavioural
// instruction ROM and 16x4 data memory.
module tb_control_unit;

   localparam logic [2:0] C_LOAD  = 3'd0;
   localparam logic [2:0] C_STORE = 3'd1;
   localparam logic [2:0] C_ADD   = 3'd2;
   localparam logic [2:0] C_SUB   = 3'd3;
   localparam logic [2:0] C_LDI   = 3'd4;
   localparam logic [2:0] C_BEQZ  = 3'd6;
   localparam logic [2:0] C_HALT  = 3'd7;

   logic        clk;
   logic        reset;
   logic        start;
   logic [3:0]  instr_addr;
   logic [11:0] instr_data;
   logic        busy;
   logic        halted;
   logic [2:0]  dbg_sel;
   logic [3:0]  dbg_data;

   logic [11:0] rom  [16];
   logic [3:0]  dmem [16];

   int n_chk;
   int n_fail;

   control_unit_if m ();

   control_unit dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .instr_addr (instr_addr),
      .instr_data (instr_data),
      .mem        (m.master),
      .busy       (busy),
      .halted     (halted),
      .dbg_sel    (dbg_sel),
      .dbg_data   (dbg_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign instr_data      = rom[instr_addr];
   assign m.mem_read_data = dmem[m.mem_address];

   // Data memory model: clears on reset, writes on enable
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) dmem[i] <= 4'd0;
      end else if (m.mem_write_enable) begin
         dmem[m.mem_address] <= m.mem_write_data;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   function automatic logic [11:0] f_mem(input logic [2:0] op, input logic [3:0] fld, input logic [2:0] rd);
      return {op, 1'b0, fld, 1'b0, rd};
   endfunction

   function automatic logic [11:0] f_reg(input logic [2:0] op, input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] rd);
      return {op, ra, rb, rd};
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reg(input string tag, input logic [2:0] idx, input logic [3:0] exp);
      dbg_sel = idx;
      #1;
      chk(tag, {12'd0, dbg_data}, {12'd0, exp});
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      start = 1'b0;
      cyc(2);
      reset = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   task automatic wait_halt(input string tag);
      for (int i = 0; i < 200 && !halted; i++) cyc(1);
      chk(tag, {15'd0, halted}, 16'd1);
   endtask

   task automatic rom_fill(input logic [11:0] w);
      for (int i = 0; i < 16; i++) rom[i] = w;
   endtask

   task automatic load_prog1();
      rom_fill(f_mem(C_HALT, 4'd0, 3'd0));
      rom[0] = f_mem(C_LDI, 4'd9, 3'd1);
      rom[1] = f_mem(C_STORE, 4'd3, 3'd1);
      rom[2] = f_mem(C_HALT, 4'd0, 3'd0);
   endtask

   logic [3:0] exp_b1;
   logic [3:0] exp_b2;

   initial begin
      n_chk   = 0;
      n_fail  = 0;
      reset   = 1'b1;
      start   = 1'b0;
      dbg_sel = 3'd0;

      // ---- LDI then STORE, reset state ----
      load_prog1();
      do_reset();
      chk("rst_busy", {15'd0, busy}, 16'd0);
      chk("rst_halted", {15'd0, halted}, 16'd0);
      chk("rst_pc", {12'd0, instr_addr}, 16'd0);
      chk("rst_we", {15'd0, m.mem_write_enable}, 16'd0);
      chk("rst_addr", {12'd0, m.mem_address}, 16'd0);
      chk_reg("rst_r1", 3'd1, 4'd0);
      pulse_start();
      for (int k = 1; k <= 9; k++) begin
         chk("t1_we", {15'd0, m.mem_write_enable}, {15'd0, (k == 6)});
         chk("t1_busy", {15'd0, busy}, {15'd0, (k <= 8)});
         if (k == 6) begin
            chk("t1_addr", {12'd0, m.mem_address}, 16'd3);
            chk("t1_wdata", {12'd0, m.mem_write_data}, 16'd9);
         end
         cyc(1);
      end
      chk("t1_halted", {15'd0, halted}, 16'd1);
      chk("t1_busy_end", {15'd0, busy}, 16'd0);
      chk("t1_pc", {12'd0, instr_addr}, 16'd2);
      chk("t1_mem3", {12'd0, dmem[3]}, 16'd9);
      chk_reg("t1_r1", 3'd1, 4'd9);
      pulse_start();
      cyc(2);
      chk("t1_start_halted", {15'd0, halted}, 16'd1);
      chk("t1_start_busy", {15'd0, busy}, 16'd0);
      chk("t1_start_pc", {12'd0, instr_addr}, 16'd2);

      // ---- Load path ----
      rom_fill(f_mem(C_HALT, 4'd0, 3'd0));
      rom[0] = f_mem(C_LDI, 4'd7, 3'd1);
      rom[1] = f_mem(C_STORE, 4'd5, 3'd1);
      rom[2] = f_mem(C_LOAD, 4'd5, 3'd2);
      do_reset();
      pulse_start();
      for (int k = 1; k <= 10; k++) begin
         chk("t2_re", {15'd0, m.mem_read_enable}, {15'd0, (k == 9)});
         if (k == 9) chk("t2_addr", {12'd0, m.mem_address}, 16'd5);
         cyc(1);
      end
      wait_halt("t2_halt");
      chk("t2_mem5", {12'd0, dmem[5]}, 16'd7);
      chk_reg("t2_r2", 3'd2, 4'd7);

      // ---- Modulo-16 arithmetic, start ignored while busy ----
      rom_fill(f_mem(C_HALT, 4'd0, 3'd0));
      rom[0] = f_mem(C_LDI, 4'd15, 3'd0);
      rom[1] = f_mem(C_LDI, 4'd2, 3'd1);
      rom[2] = f_reg(C_ADD, 3'd0, 3'd1, 3'd3);
      rom[3] = f_reg(C_SUB, 3'd1, 3'd0, 3'd4);
      do_reset();
      pulse_start();
      cyc(4);
      pulse_start();
      wait_halt("t3_halt");
      chk("t3_pc", {12'd0, instr_addr}, 16'd4);
      chk_reg("t3_r0", 3'd0, 4'd15);
      chk_reg("t3_r1", 3'd1, 4'd2);
      chk_reg("t3_add_wrap", 3'd3, 4'd1);
      chk_reg("t3_sub_wrap", 3'd4, 4'd3);

      // ---- Reset in DECODE of STORE ----
      load_prog1();
      do_reset();
      pulse_start();
      cyc(4);
      chk("t4_pc_pre", {12'd0, instr_addr}, 16'd1);
      chk("t4_busy_pre", {15'd0, busy}, 16'd1);
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      chk("t4_we0", {15'd0, m.mem_write_enable}, 16'd0);
      chk("t4_busy", {15'd0, busy}, 16'd0);
      chk("t4_pc", {12'd0, instr_addr}, 16'd0);
      chk_reg("t4_r1", 3'd1, 4'd0);
      chk("t4_mem3", {12'd0, dmem[3]}, 16'd0);
      cyc(1);
      chk("t4_we1", {15'd0, m.mem_write_enable}, 16'd0);
      chk("t4_idle_busy", {15'd0, busy}, 16'd0);
      chk("t4_idle_halted", {15'd0, halted}, 16'd0);
      pulse_start();
      wait_halt("t4_rerun_halt");
      chk("t4_rerun_mem3", {12'd0, dmem[3]}, 16'd9);
      chk("t4_rerun_pc", {12'd0, instr_addr}, 16'd2);

      // ---- Branch (BEQZ taken / not taken, or NOP without branches) ----
`ifdef CTRL_BRANCH_EN
      exp_b1 = 4'd12;
      exp_b2 = 4'd14;
`else
      exp_b1 = 4'd1;
      exp_b2 = 4'd1;
`endif
      rom_fill(f_mem(C_HALT, 4'd0, 3'd0));
      rom[0]  = f_mem(C_BEQZ, 4'd12, 3'd0);
      rom[12] = f_mem(C_LDI, 4'd1, 3'd0);
      rom[13] = f_mem(C_BEQZ, 4'd12, 3'd0);
      do_reset();
      pulse_start();
      cyc(3);
      chk("t5_beqz_first", {12'd0, instr_addr}, {12'd0, exp_b1});
      wait_halt("t5_halt");
      chk("t5_beqz_final_pc", {12'd0, instr_addr}, {12'd0, exp_b2});

      // ---- PC wraps 15 -> 0 ----
      rom_fill(f_mem(C_LDI, 4'd1, 3'd5));
      do_reset();
      pulse_start();
      cyc(45);
      chk("t6_pc15", {12'd0, instr_addr}, 16'd15);
      cyc(3);
      chk("t6_pc_wrap", {12'd0, instr_addr}, 16'd0);
      chk("t6_busy", {15'd0, busy}, 16'd1);
      do_reset();

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
